// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter
//   Shares one dual-register, edge-triggered latch block (12-bit data and
//   data3 registers) among NREQ writers. Requests are served round-robin, and
//   each write is sequenced as SETUP -> STROBE -> GAP so that the selected
//   strobe always shows a clean rising edge with lat_in already stable.
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   reset      : asynchronous, active-low reset
//   req        : per-requester write request (level, held until ack)
//   sel3       : per-requester target, 0 = data register, 1 = data3 register
//   wdata      : per-requester write data, requester i on wdata[12*i +: 12]
//   ack        : one-cycle pulse on the bit of the requester whose write is done
//   busy       : high while a transaction is in progress
//   grant_id   : index of the requester owning the current/last transaction
//   lat_in     : data to the latch block (holds the last written value)
//   lat_latch  : strobe for the data register
//   lat_latch3 : strobe for the data3 register
module latch_write_arbiter #(
  parameter int NREQ          = 4,
  parameter int STROBE_CYCLES = 1,
  parameter int GAP_CYCLES    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         sel3,
  input  logic [12*NREQ-1:0]      wdata,
  output logic [NREQ-1:0]         ack,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [11:0]             lat_in,
  output logic                    lat_latch,
  output logic                    lat_latch3
);

  localparam int DATA_W = 12;
  localparam int GW     = $clog2(NREQ);
  localparam int CMAX   = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int CW     = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] S_LAST = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [GW:0]   NREQ_W = (GW+1)'(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    GAP
  } state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [GW-1:0]      ptr, ptr_nx;
  logic               sel_q, sel_nx;
  logic [GW-1:0]      grant_nx;
  logic [DATA_W-1:0]  data_nx;
  logic [NREQ-1:0]    ack_nx;
  logic               busy_nx, latch_nx, latch3_nx;
  logic [NREQ-1:0]    rot;
  logic               found;
  logic [GW:0]        pick_sum;
  logic [GW-1:0]      pick;

  // Round-robin pick: rotate the request vector so bit 0 is the requester at
  // the pointer, take the lowest set bit, then map it back to an absolute index.
  always_comb begin
    rot      = NREQ'({req, req} >> ptr);
    found    = |rot;
    pick_sum = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) pick_sum = {1'b0, ptr} + (GW+1)'(i);
    end
    if (pick_sum >= NREQ_W) pick_sum = pick_sum - NREQ_W;
    pick = pick_sum[GW-1:0];
  end

  // Next state plus the values every registered output takes in that state,
  // so outputs line up exactly with the state they describe.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    sel_nx   = sel_q;
    grant_nx = grant_id;
    data_nx  = lat_in;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nx = SETUP;
          grant_nx = pick;
          sel_nx   = sel3[pick];
          data_nx  = wdata[DATA_W*pick +: DATA_W];
        end
      end
      SETUP: begin
        state_nx = STROBE;
        cnt_nx   = '0;
      end
      STROBE: begin
        if (cnt == S_LAST) begin
          state_nx = GAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == G_LAST) begin
          state_nx = IDLE;
          // The requester just served drops to lowest priority.
          ptr_nx   = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    busy_nx   = (state_nx != IDLE);
    latch_nx  = (state_nx == STROBE) && !sel_nx;
    latch3_nx = (state_nx == STROBE) && sel_nx;
    ack_nx    = '0;
    if (state_nx == GAP && cnt_nx == G_LAST) ack_nx[grant_nx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      sel_q      <= 1'b0;
      grant_id   <= '0;
      lat_in     <= '0;
      ack        <= '0;
      busy       <= 1'b0;
      lat_latch  <= 1'b0;
      lat_latch3 <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      ptr        <= ptr_nx;
      sel_q      <= sel_nx;
      grant_id   <= grant_nx;
      lat_in     <= data_nx;
      ack        <= ack_nx;
      busy       <= busy_nx;
      lat_latch  <= latch_nx;
      lat_latch3 <= latch3_nx;
    end
  end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Testbench for latch_write_arbiter: two instances (strobe/gap 1/1 and 3/2)
// share the same requester inputs; a transaction-level model predicts both.
module tb_latch_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, sel3;
  logic [47:0] wdata;
  logic [3:0]  ack_a, ack_b;
  logic        busy_a, busy_b, la, la3, lb, lb3;
  logic [1:0]  gid_a, gid_b;
  logic [11:0] lin_a, lin_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  latch_write_arbiter #(.NREQ(4), .STROBE_CYCLES(1), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .req(req), .sel3(sel3), .wdata(wdata),
    .ack(ack_a), .busy(busy_a), .grant_id(gid_a), .lat_in(lin_a),
    .lat_latch(la), .lat_latch3(la3)
  );

  latch_write_arbiter #(.NREQ(4), .STROBE_CYCLES(3), .GAP_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .req(req), .sel3(sel3), .wdata(wdata),
    .ack(ack_b), .busy(busy_b), .grant_id(gid_b), .lat_in(lin_b),
    .lat_latch(lb), .lat_latch3(lb3)
  );

  // Downstream latch blocks: capture lat_in on each strobe rising edge.
  logic [11:0] lbd_a, lbd3_a, lbd_b, lbd3_b;
  int cnt_la = 0, cnt_la3 = 0, cnt_lb = 0, cnt_lb3 = 0;
  always @(posedge la)  begin lbd_a  <= lin_a; cnt_la  <= cnt_la + 1;  end
  always @(posedge la3) begin lbd3_a <= lin_a; cnt_la3 <= cnt_la3 + 1; end
  always @(posedge lb)  begin lbd_b  <= lin_b; cnt_lb  <= cnt_lb + 1;  end
  always @(posedge lb3) begin lbd3_b <= lin_b; cnt_lb3 <= cnt_lb3 + 1; end

  logic [19:0] act_vec [2];
  always_comb begin
    act_vec[0] = {busy_a, ack_a, gid_a, lin_a, la, la3};
    act_vec[1] = {busy_b, ack_b, gid_b, lin_b, lb, lb3};
  end

  // Transaction model: a write occupies offsets 0 (setup), 1..S (strobe),
  // S+1..S+G (gap, ack on the last), then one idle cycle before re-arbitration.
  bit          m_act [2];
  bit          m_sel [2];
  int          m_k   [2];
  int          m_ptr [2];
  int          m_gid [2];
  int          m_np  [2] = '{0, 0};
  logic [11:0] m_data[2];
  logic [11:0] m_d   [2];
  logic [11:0] m_d3  [2];

  function automatic int s_of(int d); return (d == 0) ? 1 : 3; endfunction
  function automatic int g_of(int d); return (d == 0) ? 1 : 2; endfunction

  task automatic model_reset(int d);
    m_act[d] = 1'b0; m_k[d] = 0; m_ptr[d] = 0; m_gid[d] = 0; m_data[d] = '0; m_sel[d] = 1'b0;
  endtask

  task automatic model_edge(int d);
    if (!reset) begin
      model_reset(d);
      return;
    end
    if (m_act[d]) begin
      if (m_k[d] == s_of(d) + g_of(d)) begin
        m_act[d] = 1'b0;
        m_ptr[d] = (m_gid[d] + 1) % 4;
      end else begin
        m_k[d]++;
        if (m_k[d] == 1) begin
          m_np[d]++;
          if (m_sel[d]) m_d3[d] = m_data[d];
          else          m_d[d]  = m_data[d];
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        int j = (m_ptr[d] + i) % 4;
        if (req[j]) begin
          m_act[d] = 1'b1; m_k[d] = 0; m_gid[d] = j;
          m_sel[d] = sel3[j]; m_data[d] = wdata[12*j +: 12];
          break;
        end
      end
    end
  endtask

  function automatic logic [19:0] exp_vec(int d);
    logic [3:0] a;
    logic st;
    st = m_act[d] && m_k[d] >= 1 && m_k[d] <= s_of(d);
    a  = (m_act[d] && m_k[d] == s_of(d) + g_of(d)) ? (4'b0001 << m_gid[d]) : 4'b0000;
    return {m_act[d], a, 2'(m_gid[d]), m_data[d], st && !m_sel[d], st && m_sel[d]};
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!busy_a && !busy_b) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '0; sel3 = '0; wdata = '0;
    model_reset(0); model_reset(1);
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (act_vec[d] !== 20'h0) begin
        n_fail++; $display("FAIL reset_state dut%0d: got %h want %h", d, act_vec[d], 20'h0);
      end
    end
    reset = 1'b1;
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (act_vec[d] !== 20'h0) begin
        n_fail++; $display("FAIL idle_no_req dut%0d: got %h want %h", d, act_vec[d], 20'h0);
      end
    end
  endtask

  task automatic test_single();
    bit ok;
    wdata[11:0] = 12'o1234; sel3[0] = 1'b0; req = 4'b0001;
    tick();
    n_tests++;
    if ({busy_a, gid_a, lin_a, la, la3} !== {1'b1, 2'd0, 12'o1234, 2'b00}) begin
      n_fail++; $display("FAIL single_setup: got %h want %h", {busy_a, gid_a, lin_a, la, la3}, {1'b1, 2'd0, 12'o1234, 2'b00});
    end
    tick();
    n_tests++;
    if ({la, la3, busy_a, ack_a} !== {3'b101, 4'b0000}) begin
      n_fail++; $display("FAIL single_strobe: got %b want %b", {la, la3, busy_a, ack_a}, {3'b101, 4'b0000});
    end
    tick();
    n_tests++;
    if ({la, la3, busy_a, ack_a} !== {3'b001, 4'b0001}) begin
      n_fail++; $display("FAIL single_ack: got %b want %b", {la, la3, busy_a, ack_a}, {3'b001, 4'b0001});
    end
    req = 4'b0000;
    tick();
    n_tests++;
    if ({busy_a, ack_a, lin_a} !== {5'b0, 12'o1234}) begin
      n_fail++; $display("FAIL single_idle: got %h want %h", {busy_a, ack_a, lin_a}, {5'b0, 12'o1234});
    end
    n_tests++;
    if (lbd_a !== 12'o1234) begin
      n_fail++; $display("FAIL single_latched: got %o want %o", lbd_a, 12'o1234);
    end
    wait_idle(ok);
    n_tests++;
    if (!ok || lbd_b !== 12'o1234) begin
      n_fail++; $display("FAIL single_latched_b: idle %0d got %o want %o", ok, lbd_b, 12'o1234);
    end
  endtask

  task automatic test_pair();
    int q[$];
    int got;
    bit ok;
    wdata[23:12] = 12'o0007; sel3[1] = 1'b0;
    wdata[35:24] = 12'o7700; sel3[2] = 1'b1;
    req = 4'b0110;
    for (int c = 0; c < 40 && q.size() < 2; c++) begin
      tick();
      if (la) begin
        n_tests++;
        if (gid_a !== 2'd1 || la3 !== 1'b0) begin
          n_fail++; $display("FAIL pair_latch_owner: got gid %0d l3 %b want gid 1 l3 0", gid_a, la3);
        end
      end
      if (la3) begin
        n_tests++;
        if (gid_a !== 2'd2) begin
          n_fail++; $display("FAIL pair_latch3_owner: got gid %0d want 2", gid_a);
        end
      end
      for (int i = 0; i < 4; i++) if (ack_a[i]) begin q.push_back(i); req[i] = 1'b0; end
    end
    req = 4'b0000;
    got = (q.size() == 2) ? 100 + q[0] * 10 + q[1] : q.size();
    n_tests++;
    if (got != 112) begin
      n_fail++; $display("FAIL pair_order: got code %0d want 112 (grant 1 then 2)", got);
    end
    wait_idle(ok);
    n_tests++;
    if (!ok || lbd_a !== 12'o0007 || lbd3_a !== 12'o7700) begin
      n_fail++; $display("FAIL pair_regs: idle %0d got data %o data3 %o want 0007 7700", ok, lbd_a, lbd3_a);
    end
  endtask

  task automatic test_fairness();
    int q[$];
    int got;
    bit ok;
    reset = 1'b0; tick(); reset = 1'b1;
    wdata[11:0] = 12'o0100; wdata[47:36] = 12'o0303; sel3 = 4'b0000;
    req = 4'b1001;
    for (int c = 0; c < 80 && q.size() < 3; c++) begin
      tick();
      for (int i = 0; i < 4; i++) if (ack_a[i]) begin
        q.push_back(i);
        if (i == 3) req[3] = 1'b0;
      end
    end
    req = 4'b0000;
    got = (q.size() == 3) ? 1000 + q[0] * 100 + q[1] * 10 + q[2] : q.size();
    n_tests++;
    if (got != 1030) begin
      n_fail++; $display("FAIL fair_order: got code %0d want 1030 (0,3,0)", got);
    end
    wait_idle(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL fair_idle: got busy want idle"); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wdata[23:12] = 12'o4321; sel3[1] = 1'b1;
    wdata[47:36] = 12'o0033; sel3[3] = 1'b0;
    req = 4'b1010;
    tick(); tick();
    n_tests++;
    if ((la | la3) !== 1'b1) begin
      n_fail++; $display("FAIL rmid_in_strobe: got %b want 1", la | la3);
    end
    reset = 1'b0;
    #1;
    model_reset(0); model_reset(1);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (act_vec[d] !== 20'h0) begin
        n_fail++; $display("FAIL rmid_clear dut%0d: got %h want %h", d, act_vec[d], 20'h0);
      end
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if ({ack_a, ack_b, busy_a, busy_b} !== 10'b0) begin
        n_fail++; $display("FAIL rmid_no_ack: got %b want 0", {ack_a, ack_b, busy_a, busy_b});
      end
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if ({busy_a, gid_a, lin_a, busy_b, gid_b, lin_b} !== {1'b1, 2'd1, 12'o4321, 1'b1, 2'd1, 12'o4321}) begin
      n_fail++; $display("FAIL rmid_regrant: got %h want %h", {busy_a, gid_a, lin_a, busy_b, gid_b, lin_b},
                         {1'b1, 2'd1, 12'o4321, 1'b1, 2'd1, 12'o4321});
    end
    req = 4'b0000;
    wait_idle(ok);
  endtask

  task automatic test_timing();
    bit ok;
    int nl, nl3;
    wdata[11:0] = 12'o0525; sel3[0] = 1'b0; req = 4'b0001;
    nl = cnt_lb; nl3 = cnt_lb3;
    tick();
    n_tests++;
    if ({busy_b, lin_b, lb} !== {1'b1, 12'o0525, 1'b0}) begin
      n_fail++; $display("FAIL timing_setup: got %h want %h", {busy_b, lin_b, lb}, {1'b1, 12'o0525, 1'b0});
    end
    req = 4'b0000;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_tests++;
      if ({lb, lb3, ack_b} !== {k <= 3, 1'b0, (k == 5) ? 4'b0001 : 4'b0000}) begin
        n_fail++; $display("FAIL timing_k%0d: got %b want %b", k, {lb, lb3, ack_b},
                           {k <= 3, 1'b0, (k == 5) ? 4'b0001 : 4'b0000});
      end
    end
    n_tests++;
    if (cnt_lb - nl != 1 || cnt_lb3 - nl3 != 0 || lbd_b !== 12'o0525) begin
      n_fail++; $display("FAIL timing_captures: got %0d/%0d %o want 1/0 0525", cnt_lb - nl, cnt_lb3 - nl3, lbd_b);
    end
    wait_idle(ok);
  endtask

  task automatic test_capture();
    bit ok;
    bit seen;
    wdata[11:0] = 12'o1111; sel3[0] = 1'b0; req = 4'b0001;
    tick();
    wdata[11:0] = 12'o2222;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (ack_a[0]) seen = 1'b1;
    end
    req = 4'b0000;
    n_tests++;
    if (!seen || lbd_a !== 12'o1111 || lin_a !== 12'o1111) begin
      n_fail++; $display("FAIL capture_a: ack %0d got %o/%o want 1111", seen, lbd_a, lin_a);
    end
    wait_idle(ok);
    n_tests++;
    if (!ok || lbd_b !== 12'o1111) begin
      n_fail++; $display("FAIL capture_b: idle %0d got %o want 1111", ok, lbd_b);
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if (ack_a[i] || $urandom_range(0, 31) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          sel3[i] = 1'($urandom_range(0, 1));
          wdata[12*i +: 12] = 12'($urandom);
        end
        if ($urandom_range(0, 15) == 0) wdata[12*i +: 12] = 12'($urandom);
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (act_vec[d] !== exp_vec(d)) begin
          n_fail++; $display("FAIL rand_dut%0d cycle %0d: got %h want %h", d, c, act_vec[d], exp_vec(d));
        end
      end
      n_tests++;
      if ((la && la3) || (lb && lb3)) begin
        n_fail++; $display("FAIL rand_two_strobes cycle %0d: got %b want no pair", c, {la, la3, lb, lb3});
      end
    end
    req = 4'b0000;
    wait_idle(ok);
    n_tests++;
    if (!ok || lbd_a !== m_d[0] || lbd3_a !== m_d3[0] || cnt_la + cnt_la3 != m_np[0]) begin
      n_fail++; $display("FAIL rand_block_a: got %o %o %0d want %o %o %0d", lbd_a, lbd3_a, cnt_la + cnt_la3, m_d[0], m_d3[0], m_np[0]);
    end
    n_tests++;
    if (!ok || lbd_b !== m_d[1] || lbd3_b !== m_d3[1] || cnt_lb + cnt_lb3 != m_np[1]) begin
      n_fail++; $display("FAIL rand_block_b: got %o %o %0d want %o %o %0d", lbd_b, lbd3_b, cnt_lb + cnt_lb3, m_d[1], m_d3[1], m_np[1]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_pair();
    test_fairness();
    test_reset_mid();
    test_timing();
    test_capture();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
